// File: rtl/pwm_ramp_scheduler_if.sv
// Command/strobe bundle between the SPI decoder, the ramp scheduler and the PWM/divider blocks.
interface pwm_ramp_scheduler_if #(
    parameter int COMPARE_SIZE = 8,
    parameter int NUM_CH       = 8,
    parameter int CLK_DIV_SIZE = 3
);
    logic                    cmd_valid;
    logic [15:0]             cmd_data;
    logic                    cmd_ready;
    logic [NUM_CH-1:0]       pwm_wr;
    logic [COMPARE_SIZE-1:0] compare_out;
    logic                    div_wr;
    logic [CLK_DIV_SIZE-1:0] div_data;
    logic                    ramp_busy;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, pwm_wr, compare_out, div_wr, div_data, ramp_busy
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, pwm_wr, compare_out, div_wr, div_data, ramp_busy
    );
endinterface

// File: rtl/pwm_ramp_scheduler.sv
// Shared compare-bus arbiter: host writes versus a per-channel fade engine stepping cur toward tgt.
// Optional macro PWM_RAMP_STARVE_GUARD_EN drops cmd_ready one cycle in four so ramps are never starved.
module pwm_ramp_scheduler #(
    parameter int COMPARE_SIZE = 8,
    parameter int NUM_CH       = 8,
    parameter int CLK_DIV_SIZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    pwm_ramp_scheduler_if.slave bus
);

    function automatic logic [COMPARE_SIZE-1:0] step_toward(
        input logic [COMPARE_SIZE-1:0] cur,
        input logic [COMPARE_SIZE-1:0] tgt
    );
        logic [COMPARE_SIZE-1:0] nxt;
        nxt = cur;
        if (cur < tgt && cur != '1)
            nxt = cur + 1'b1;
        else if (cur > tgt && cur != '0)
            nxt = cur - 1'b1;
        return nxt;
    endfunction

    logic [COMPARE_SIZE-1:0] r_cur [NUM_CH];
    logic [COMPARE_SIZE-1:0] r_tgt [NUM_CH];
    logic [NUM_CH-1:0]       r_active;
    logic [NUM_CH-1:0]       r_pending;
    logic [COMPARE_SIZE-1:0] r_period;
    logic [COMPARE_SIZE-1:0] r_count;
    logic [2:0]              r_rr;
    logic [NUM_CH-1:0]       r_pwm_wr;
    logic [COMPARE_SIZE-1:0] r_compare_out;
    logic                    r_div_wr;
    logic [CLK_DIV_SIZE-1:0] r_div_data;
    logic                    r_cmd_ready;

    logic                    w_accept;
    logic [3:0]              w_addr;
    logic [2:0]              w_cmd_ch;
    logic [COMPARE_SIZE-1:0] w_val;
    logic                    w_dir_ok;
    logic                    w_tgt_ok;
    logic                    w_tick;
    logic                    w_grant_vld;
    logic [2:0]              w_grant_ch;
    logic [2:0]              w_scan;
    logic [COMPARE_SIZE-1:0] w_step;
    logic [NUM_CH-1:0]       w_active_n;
    logic [NUM_CH-1:0]       w_pend_clr;
    logic                    w_unused;

    assign w_accept = bus.cmd_valid & r_cmd_ready;
    assign w_addr   = bus.cmd_data[15:12];
    assign w_cmd_ch = bus.cmd_data[10:8];
    assign w_val    = COMPARE_SIZE'(bus.cmd_data[7:0]);
    assign w_unused = bus.cmd_data[11];
    assign w_dir_ok = (w_addr[3] == 1'b0) && (int'(w_addr[2:0]) < NUM_CH);
    assign w_tgt_ok = (w_addr == 4'h9) && (int'(w_cmd_ch) < NUM_CH);
    assign w_tick   = (r_period != '0) && (r_count == r_period - 1'b1);

    // Round-robin scan; descending loop so the nearest pending channel at/after r_rr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_scan      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan = 3'((int'(r_rr) + k) % NUM_CH);
            if (r_pending[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_scan;
            end
        end
    end

    assign w_step = step_toward(r_cur[w_grant_ch], r_tgt[w_grant_ch]);

    always_comb begin
        w_active_n = r_active;
        w_pend_clr = '0;
        if (w_accept) begin
            if (w_dir_ok) begin
                w_active_n[w_addr[2:0]] = 1'b0;
                w_pend_clr[w_addr[2:0]] = 1'b1;
            end else if (w_tgt_ok) begin
                w_active_n[w_cmd_ch] = (w_val != r_cur[w_cmd_ch]);
                w_pend_clr[w_cmd_ch] = (w_val == r_cur[w_cmd_ch]);
            end
        end else if (w_grant_vld) begin
            w_pend_clr[w_grant_ch] = 1'b1;
            if (w_step == r_tgt[w_grant_ch])
                w_active_n[w_grant_ch] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cur[i] <= '0;
                r_tgt[i] <= '0;
            end
            r_active      <= '0;
            r_pending     <= '0;
            r_period      <= '0;
            r_count       <= '0;
            r_rr          <= '0;
            r_pwm_wr      <= '0;
            r_compare_out <= '0;
            r_div_wr      <= 1'b0;
            r_div_data    <= '0;
        end else begin
            r_pwm_wr      <= '0;
            r_compare_out <= '0;
            r_div_wr      <= 1'b0;
            r_div_data    <= '0;
            if (w_accept) begin
                if (w_dir_ok) begin
                    r_cur[w_addr[2:0]] <= w_val;
                    r_pwm_wr           <= NUM_CH'(1) << w_addr[2:0];
                    r_compare_out      <= w_val;
                end else if (w_addr == 4'h8) begin
                    r_div_wr   <= 1'b1;
                    r_div_data <= w_val[CLK_DIV_SIZE-1:0];
                end else if (w_tgt_ok) begin
                    r_tgt[w_cmd_ch] <= w_val;
                end else if (w_addr == 4'hA) begin
                    r_period <= w_val;
                end
            end else if (w_grant_vld) begin
                r_cur[w_grant_ch] <= w_step;
                r_pwm_wr          <= NUM_CH'(1) << w_grant_ch;
                r_compare_out     <= w_step;
                r_rr              <= 3'((int'(w_grant_ch) + 1) % NUM_CH);
            end
            r_active  <= w_active_n;
            // A tick merges into pending, so a channel already waiting is not queued twice.
            r_pending <= (r_pending & ~w_pend_clr) | (w_tick ? w_active_n : '0);
            if (w_accept && w_addr == 4'hA)
                r_count <= '0;
            else if (r_period != '0)
                r_count <= w_tick ? '0 : r_count + 1'b1;
        end
    end

`ifdef PWM_RAMP_STARVE_GUARD_EN
    logic [1:0] r_starve_cnt;

    // Third consecutive host grant with ramps waiting: withhold ready for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_cmd_ready  <= 1'b0;
        end else if (w_accept && (r_pending != '0)) begin
            if (r_starve_cnt == 2'd2) begin
                r_starve_cnt <= '0;
                r_cmd_ready  <= 1'b0;
            end else begin
                r_starve_cnt <= r_starve_cnt + 2'd1;
                r_cmd_ready  <= 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
            r_cmd_ready  <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cmd_ready <= 1'b0;
        else
            r_cmd_ready <= 1'b1;
    end
`endif

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.pwm_wr      = r_pwm_wr;
    assign bus.compare_out = r_compare_out;
    assign bus.div_wr      = r_div_wr;
    assign bus.div_data    = r_div_data;
    assign bus.ramp_busy   = |r_active;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Randomized and directed bench for pwm_ramp_scheduler against a per-cycle behavioural model.
module tb_pwm_ramp_scheduler;
    localparam int NUM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_ramp_scheduler_if #(.COMPARE_SIZE(8), .NUM_CH(NUM), .CLK_DIV_SIZE(3)) bus ();

    pwm_ramp_scheduler #(.COMPARE_SIZE(8), .NUM_CH(NUM), .CLK_DIV_SIZE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state, in plain integers
    int m_cur [NUM];
    int m_tgt [NUM];
    bit m_act [NUM];
    bit m_pend[NUM];
    int m_period, m_cnt, m_rr, m_gcnt;
    int e_pwm, e_cmp, e_div, e_divd, e_ready, e_busy;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_act[i] = 0; m_pend[i] = 0;
        end
        m_period = 0; m_cnt = 0; m_rr = 0; m_gcnt = 0;
        e_pwm = 0; e_cmp = 0; e_div = 0; e_divd = 0; e_ready = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d);
        int  addr, ch, val, g, old_period;
        bit  acc, tick, anyp;
        addr = int'(d[15:12]);
        ch   = int'(d[10:8]);
        val  = int'(d[7:0]);
        acc  = v && (e_ready != 0);
        old_period = m_period;
        tick = (m_period != 0) && (m_cnt == m_period - 1);
        anyp = 0;
        for (int i = 0; i < NUM; i++) anyp |= m_pend[i];
        e_pwm = 0; e_cmp = 0; e_div = 0; e_divd = 0;
        if (acc) begin
            if (addr < 8) begin
                if (addr < NUM) begin
                    m_cur[addr] = val; m_act[addr] = 0; m_pend[addr] = 0;
                    e_pwm = 1 << addr; e_cmp = val;
                end
            end else if (addr == 8) begin
                e_div = 1; e_divd = val % 8;
            end else if (addr == 9) begin
                if (ch < NUM) begin
                    m_tgt[ch] = val;
                    m_act[ch] = (val != m_cur[ch]);
                    if (!m_act[ch]) m_pend[ch] = 0;
                end
            end else if (addr == 10) begin
                m_period = val;
            end
        end else if (anyp) begin
            g = -1;
            for (int k = 0; k < NUM; k++)
                if (g < 0 && m_pend[(m_rr + k) % NUM]) g = (m_rr + k) % NUM;
            m_cur[g] = m_cur[g] + ((m_tgt[g] > m_cur[g]) ? 1 : -1);
            m_pend[g] = 0;
            if (m_cur[g] == m_tgt[g]) m_act[g] = 0;
            m_rr = (g + 1) % NUM;
            e_pwm = 1 << g; e_cmp = m_cur[g];
        end
        if (tick)
            for (int i = 0; i < NUM; i++) m_pend[i] |= m_act[i];
        if (acc && addr == 10) m_cnt = 0;
        else if (old_period != 0) m_cnt = tick ? 0 : m_cnt + 1;
`ifdef PWM_RAMP_STARVE_GUARD_EN
        if (acc && anyp) begin
            if (m_gcnt == 2) begin m_gcnt = 0; e_ready = 0; end
            else begin m_gcnt++; e_ready = 1; end
        end else begin
            m_gcnt = 0; e_ready = 1;
        end
`else
        e_ready = 1;
`endif
        e_busy = 0;
        for (int i = 0; i < NUM; i++) e_busy |= int'(m_act[i]);
    endtask

    task automatic cycle(input logic v, input logic [15:0] d);
        bus.cmd_valid = v;
        bus.cmd_data  = d;
        model_step(v, d);
        @(negedge clk);
        cyc++;
        check_eq("pwm_wr",      32'(bus.pwm_wr),      32'(e_pwm));
        check_eq("compare_out", 32'(bus.compare_out), 32'(e_cmp));
        check_eq("div_wr",      32'(bus.div_wr),      32'(e_div));
        check_eq("div_data",    32'(bus.div_data),    32'(e_divd));
        check_eq("cmd_ready",   32'(bus.cmd_ready),   32'(e_ready));
        check_eq("ramp_busy",   32'(bus.ramp_busy),   32'(e_busy));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pwm_wr"},    32'(bus.pwm_wr),      32'd0);
        check_eq({tag, "_cmp"},       32'(bus.compare_out), 32'd0);
        check_eq({tag, "_div_wr"},    32'(bus.div_wr),      32'd0);
        check_eq({tag, "_div_data"},  32'(bus.div_data),    32'd0);
        check_eq({tag, "_ready"},     32'(bus.cmd_ready),   32'd0);
        check_eq({tag, "_busy"},      32'(bus.ramp_busy),   32'd0);
    endtask

    int q_t[$];
    int q_v[$];
    int found, lows, strobes, sel, ch, val;

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        cycle(1'b0, 16'h0000);

        // Direct write and divider
        cycle(1'b1, 16'h3080);
        check_eq("dir_pwm", 32'(bus.pwm_wr), 32'h08);
        check_eq("dir_cmp", 32'(bus.compare_out), 32'h80);
        cycle(1'b0, 16'h0000);
        check_eq("dir_once", 32'(bus.pwm_wr), 32'h00);
        cycle(1'b1, 16'h8005);
        check_eq("div_wr", 32'(bus.div_wr), 32'd1);
        check_eq("div_val", 32'(bus.div_data), 32'd5);
        cycle(1'b0, 16'h0000);
        check_eq("div_once", 32'(bus.div_wr), 32'd0);

        // Ramp up ch2 from 0 to 3 with period 4
        cycle(1'b1, 16'hA004);
        cycle(1'b1, 16'h9203);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 16'h0000);
            if (bus.pwm_wr[2]) begin
                q_t.push_back(cyc);
                q_v.push_back(int'(bus.compare_out));
            end
        end
        check_eq("ramp_count", 32'(q_v.size()), 32'd3);
        if (q_v.size() == 3) begin
            check_eq("ramp_v0", 32'(q_v[0]), 32'd1);
            check_eq("ramp_v1", 32'(q_v[1]), 32'd2);
            check_eq("ramp_v2", 32'(q_v[2]), 32'd3);
            check_eq("ramp_gap0", 32'(q_t[1] - q_t[0]), 32'd4);
            check_eq("ramp_gap1", 32'(q_t[2] - q_t[1]), 32'd4);
        end
        check_eq("ramp_idle_busy", 32'(bus.ramp_busy), 32'd0);

        // Cancel ch2 ramp with a direct write after its first step
        cycle(1'b1, 16'h9208);
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            cycle(1'b0, 16'h0000);
            if (bus.pwm_wr[2]) found = 1;
        end
        check_eq("cancel_first_step", 32'(found), 32'd1);
        cycle(1'b1, 16'h2010);
        check_eq("cancel_cmp", 32'(bus.compare_out), 32'h10);
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 16'h0000);
            if (bus.pwm_wr[2]) strobes++;
        end
        check_eq("cancel_no_steps", 32'(strobes), 32'd0);
        check_eq("cancel_busy", 32'(bus.ramp_busy), 32'd0);

        // Asynchronous reset in the middle of a ramp
        cycle(1'b1, 16'h9280);
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000);
        check_eq("midramp_busy", 32'(bus.ramp_busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        cycle(1'b0, 16'h0000);

        // Round robin against a host write on the cycle after a tick
        cycle(1'b1, 16'hA004);
        cycle(1'b1, 16'h9005);
        cycle(1'b1, 16'h9508);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (m_period != 0 && m_cnt == m_period - 1) found = 1;
            else cycle(1'b0, 16'h0000);
        end
        check_eq("rr_tick_found", 32'(found), 32'd1);
        cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h7042);
        check_eq("rr_host", 32'(bus.pwm_wr), 32'h80);
        check_eq("rr_host_cmp", 32'(bus.compare_out), 32'h42);
        cycle(1'b0, 16'h0000);
        check_eq("rr_ch0", 32'(bus.pwm_wr), 32'h01);
        check_eq("rr_ch0_cmp", 32'(bus.compare_out), 32'h01);
        cycle(1'b0, 16'h0000);
        check_eq("rr_ch5", 32'(bus.pwm_wr), 32'h20);
        check_eq("rr_ch5_cmp", 32'(bus.compare_out), 32'h01);

        // Host holding cmd_valid while ramps are pending
        cycle(1'b1, 16'hA001);
        cycle(1'b1, 16'h91FF);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);
        lows = 0;
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.cmd_ready == 1'b0) lows++;
            cycle(1'b1, 16'hB000);
            if (bus.pwm_wr != '0) strobes++;
        end
`ifdef PWM_RAMP_STARVE_GUARD_EN
        check_eq("guard_lows", 32'(lows), 32'd4);
        check_eq("guard_strobes", 32'(strobes), 32'd4);
`else
        check_eq("noguard_lows", 32'(lows), 32'd0);
        check_eq("noguard_strobes", 32'(strobes), 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 15));
            ch  = int'($urandom_range(0, 7));
            val = int'($urandom_range(0, 255));
            if (sel == 10) val = int'($urandom_range(0, 5));
            if (sel == 9 && $urandom_range(0, 1) == 1) val = int'($urandom_range(0, 12));
            cycle(1'($urandom_range(0, 1)),
                  16'((sel << 12) | (int'($urandom_range(0, 1)) << 11) | (ch << 8) | val));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_scheduler.md
Name: pwm_ramp_scheduler

Overview:
- Sits between the SPI command decoder and the 8 pwm_generator instances plus the clock_divider.
- Owns the single shared compare bus and issues one-hot write strobes to the PWM generators.
- Arbitrates between direct host writes and an autonomous per-channel ramp (fade) engine that steps each channel's compare value toward a target at a programmable rate.

Parameters:
- COMPARE_SIZE, 8, compare/duty width.
- NUM_CH, 8, number of PWM channels (max 8; channel field is 3 bits).
- CLK_DIV_SIZE, 3, clock_divider setting width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command word present (one-cycle pulse per SPI frame)
- cmd_data  in  16  command word: [15:12] addr, [10:8] channel, [7:0] value
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- pwm_wr  out  NUM_CH  one-hot write strobe to pwm_generator wr
- compare_out  out  COMPARE_SIZE  shared compare bus, valid with pwm_wr
- div_wr  out  1  write strobe to clock_divider
- div_data  out  CLK_DIV_SIZE  divider value, valid with div_wr
- ramp_busy  out  1  OR of all channel ramp-active flags

Behaviour:
Reset:
- Asynchronous, any time, including mid-ramp.
- All outputs 0, except cmd_ready, which is 1 once rst deasserts.
- Internal state cleared: cur[ch]=0, tgt[ch]=0, active=0, pending=0, period=0, step counter=0, round-robin pointer=0.

Command decode (on accept):
- addr 0x0-0x7: direct write to ch=addr[2:0]; cur[ch]=value; clears active[ch] and pending[ch] in the same cycle.
- addr 0x8: div_wr pulse, div_data=value[CLK_DIV_SIZE-1:0].
- addr 0x9: tgt[ch]=value with ch=cmd_data[10:8]; active[ch]=(value!=cur[ch]). Retarget mid-ramp keeps cur.
- addr 0xA: period=value; step counter reset to 0.
- Other addresses: accepted and ignored, no strobe.
- Channel index >= NUM_CH: ignored.

Step timer:
- period=0: timer halted, no ticks.
- Otherwise the counter runs 0..period-1 and wraps; tick fires in the cycle count==period-1.
- On tick, pending |= active. Merging means a channel is never stepped twice per tick.

Arbitration (one write per cycle):
- Host command has priority.
- Otherwise, grant the lowest-index pending channel at or above the rr pointer, wrapping around; pointer then becomes granted+1 mod NUM_CH.
- Ramp grant: cur moves ±1 toward tgt, is written out, and pending[ch] clears. active[ch] clears when cur reaches tgt.
- No wrap-around past 0 or 2^COMPARE_SIZE-1.

Output timing:
- Registered, single-cycle pulses.
- Host accept in cycle N: pwm_wr/div_wr is high in cycle N+1 only, with data valid in N+1.
- Ramp: tick in cycle T gives the earliest strobe in T+2.
- At most one bit of {pwm_wr, div_wr} is high per cycle.

cmd_ready:
- Held at 1, except as described under Optional Feature.
- Host traffic may starve ramps unless that feature is enabled.

Optional Feature:
- Macro: PWM_RAMP_STARVE_GUARD_EN.
- Enabled:
  - A 2-bit counter tracks consecutive host grants made while pending!=0.
  - When it reaches 3, cmd_ready=0 for the next cycle, forcing one ramp grant. The counter then clears.
  - The counter also clears on any cycle with no host grant.
- Disabled: cmd_ready is constant 1 after reset; no counter is synthesized.

Test Plan:
- Reset/direct write:
  - Stimulus: after rst, cmd 0x3_0_80 accepted at cycle N.
  - Response: pwm_wr=8'b0000_1000 and compare_out=0x80 in N+1 only; all outputs 0 during rst.
- Divider:
  - Stimulus: cmd 0x8005.
  - Response: div_wr=1 and div_data=3'b101 for exactly one cycle; pwm_wr stays 0.
- Ramp up:
  - Stimulus: period=4 (0xA004), then target 0x9_2_03 on ch2 starting from cur=0.
  - Response: ch2 written 1, 2, 3 with strobes spaced 4 cycles apart; ramp_busy falls after value 3; no further ch2 writes.
- Round-robin plus simultaneous tick:
  - Stimulus: ch0 and ch5 both active; host issues a direct write on the tick+1 cycle.
  - Response: host strobe first, then ch0, then ch5 on consecutive cycles.
- Cancel/reset mid-ramp:
  - Stimulus: direct write to ch2=0x10 during its ramp.
  - Response: no further ramp strobes for ch2.
  - Stimulus: async rst asserted mid-ramp.
  - Response: outputs 0 immediately; ramp_busy=0.
- Starve guard (macro enabled):
  - Stimulus: cmd_valid held high with a pending ramp.
  - Response: cmd_ready low on every 4th cycle, and the ramp strobe appears in that slot.
  - With the macro disabled: cmd_ready never drops.
